// File: rtl/fsk_packet_mod.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fsk_packet_mod : preamble/sync/payload packetiser, binary-FSK out   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fsk_packet_mod #(
  parameter int unsigned BIT_CYCLES     = 12000,
  parameter int unsigned PREAMBLE_BYTES = 2,
  parameter logic [7:0]  SYNC_WORD      = 8'hD3,
  parameter int unsigned GAP_BITS       = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cw_0_in,
  input  logic       cw_1_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rf_out,
  output logic       busy,
  output logic       bit_strobe,
  output logic       underrun
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int PRE_W = $clog2(PREAMBLE_BYTES + 1);
  localparam int GAP_W = $clog2(GAP_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [PRE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             cur_last_q, cur_last_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             hold_last_q, hold_last_d;
  logic             alive_q;
  logic             cw0_meta_q, cw0_sync_q, cw1_meta_q, cw1_sync_q;
  logic             rf_q, rf_d;

  logic             strobe;
  logic             byte_end;
  logic             sending;
  logic             load_hold;
  logic             accept;

  assign strobe     = (cnt_q == CNT_MAX);
  assign byte_end   = strobe && (bit_idx_q == 3'd7);
  assign sending    = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) ||
                      (state_q == ST_PAYLOAD);
  // alive_q keeps tx_ready low until the first clock after reset release
  assign tx_ready   = alive_q && !hold_full_q;
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state_q != ST_IDLE);
  assign bit_strobe = strobe;
  assign rf_out     = rf_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    cur_last_d = cur_last_q;
    load_hold  = 1'b0;
    underrun   = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = strobe ? '0 : cnt_q + 1'b1;
    end
    if (sending && strobe) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        bit_idx_d  = 3'd0;
        byte_cnt_d = '0;
        gap_cnt_d  = '0;
        shift_d    = 8'hAA;
        if (hold_full_q) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (byte_end) begin
          if (byte_cnt_q == PRE_LAST) begin
            shift_d    = SYNC_WORD;
            byte_cnt_d = '0;
            state_d    = ST_SYNC;
          end else begin
            shift_d    = 8'hAA;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (byte_end) begin
          shift_d    = hold_data_q;
          cur_last_d = hold_last_q;
          load_hold  = 1'b1;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (byte_end) begin
          if (cur_last_q) begin
            state_d = ST_GAP;
          end else if (hold_full_q) begin
            shift_d    = hold_data_q;
            cur_last_d = hold_last_q;
            load_hold  = 1'b1;
          end else begin
            underrun = 1'b1;
            state_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (strobe) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A load frees the buffer; a handshake can only land while it is already empty
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    if (load_hold) hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
      hold_last_d = tx_last;
    end
  end

  always_comb begin
    rf_d = 1'b0;
    if (sending) rf_d = shift_q[7] ? cw1_sync_q : cw0_sync_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      shift_q     <= 8'h00;
      cur_last_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
      alive_q     <= 1'b0;
      cw0_meta_q  <= 1'b0;
      cw0_sync_q  <= 1'b0;
      cw1_meta_q  <= 1'b0;
      cw1_sync_q  <= 1'b0;
      rf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shift_q     <= shift_d;
      cur_last_q  <= cur_last_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      alive_q     <= 1'b1;
      cw0_meta_q  <= cw_0_in;
      cw0_sync_q  <= cw0_meta_q;
      cw1_meta_q  <= cw_1_in;
      cw1_sync_q  <= cw1_meta_q;
      rf_q        <= rf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fsk_packet_mod.sv
`default_nettype none
// tb_fsk_packet_mod : randomised packets checked against a per-packet schedule
// built from bit-period arithmetic (cycle index = number of clock edges seen).
module tb_fsk_packet_mod;

  localparam int BC   = 4;
  localparam int PB   = 1;
  localparam int GB   = 2;
  localparam logic [7:0] SYNC = 8'hD3;
  localparam int HDR  = 8 * (PB + 1);
  localparam int N    = 16384;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cw0 = 1'b0;
  logic       cw1 = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, rf_out, busy, bit_strobe, underrun;

  fsk_packet_mod #(
    .BIT_CYCLES(BC), .PREAMBLE_BYTES(PB), .SYNC_WORD(SYNC), .GAP_BITS(GB)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .cw_0_in(cw0), .cw_1_in(cw1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .rf_out(rf_out), .busy(busy),
    .bit_strobe(bit_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  bit         e_act[N], e_bit[N], e_busy[N], e_stb[N], e_und[N], e_full[N];
  bit         d_val[N], d_last[N];
  logic [7:0] d_data[N];
  bit         h_cw0[N], h_cw1[N];
  logic [7:0] pl[8];
  int         next_free, prev_gend, last_s;
  bit         cw_static, cw_static0, cw_static1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit rf_e;
    if (mon_en && cyc >= 3 && cyc < N) begin
      rf_e = e_act[cyc-1] ? (e_bit[cyc-1] ? h_cw1[cyc-3] : h_cw0[cyc-3]) : 1'b0;
      check_eq("busy", busy, e_busy[cyc]);
      check_eq("bit_strobe", bit_strobe, e_stb[cyc]);
      check_eq("underrun", underrun, e_und[cyc]);
      check_eq("tx_ready", tx_ready, !e_full[cyc]);
      check_eq("rf_out", rf_out, rf_e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (cw_static) begin
      cw0 = cw_static0;
      cw1 = cw_static1;
    end else begin
      if ($urandom_range(0, 2) == 0) cw0 = ~cw0;
      if ($urandom_range(0, 3) == 0) cw1 = ~cw1;
    end
    h_cw0[cyc] = cw0;
    h_cw1[cyc] = cw1;
    tx_valid = d_val[cyc];
    tx_data  = d_val[cyc] ? d_data[cyc] : 8'($urandom);
    tx_last  = d_val[cyc] ? d_last[cyc] : 1'($urandom);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step();
  endtask

  // Schedule one packet of n payload bytes (pl[0..n-1]); trunc withholds byte n.
  task automatic plan(input int n, input bit trunc, input int delay);
    int h0, s, e, xp, p, x, lj, lprev;
    h0 = next_free + delay;
    s  = (h0 > prev_gend) ? h0 + 2 : prev_gend + 2;
    last_s = s;
    for (int k = 0; k < HDR + 8 * n; k++) begin
      logic [7:0] by;
      by = (k < 8 * PB) ? 8'hAA : (k < HDR) ? SYNC : pl[(k - HDR) / 8];
      for (int i = 0; i < BC; i++) begin
        e_act[s + BC * k + i] = 1'b1;
        e_bit[s + BC * k + i] = by[7 - (k % 8)];
      end
      e_stb[s + BC * k + BC - 1] = 1'b1;
    end
    e = s + BC * (HDR + 8 * n) - 1;
    if (trunc) e_und[e] = 1'b1;
    for (int g = 1; g <= GB; g++) e_stb[e + BC * g] = 1'b1;
    for (int c = s; c <= e + BC * GB; c++) e_busy[c] = 1'b1;

    d_val[h0]  = 1'b1;
    d_data[h0] = pl[0];
    d_last[h0] = !trunc && (n == 1);
    lj = s + BC * HDR - 1;
    for (int c = h0 + 1; c <= lj; c++) e_full[c] = 1'b1;
    xp = h0;
    for (int j = 1; j < n; j++) begin
      lprev = lj;
      lj    = s + BC * (HDR + 8 * j) - 1;
      p     = xp + 1 + int'($urandom_range(0, lj - 2 - xp));
      x     = (p > lprev + 1) ? p : lprev + 1;
      for (int c = p; c <= x; c++) begin
        d_val[c]  = 1'b1;
        d_data[c] = pl[j];
        d_last[c] = !trunc && (j == n - 1);
      end
      for (int c = x + 1; c <= lj; c++) e_full[c] = 1'b1;
      xp = x;
    end
    prev_gend = e + BC * GB;
    next_free = trunc ? e : lj + 1;
  endtask

  initial begin
    cw_static = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    #2;
    check_eq("reset rf_out", rf_out, 1'b0);
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset tx_ready", tx_ready, 1'b0);
    check_eq("reset bit_strobe", bit_strobe, 1'b0);
    check_eq("reset underrun", underrun, 1'b0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    next_free = cyc + 2;
    prev_gend = -100;

    pl[0] = 8'h5A;
    plan(1, 1'b0, 0);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    plan(3, 1'b0, 0);
    pl[0] = 8'hC4;
    plan(1, 1'b1, 0);
    pl[0] = 8'h96; pl[1] = 8'h0F;
    plan(2, 1'b0, 1);
    run_until(prev_gend + 3);

    cw_static = 1'b1; cw_static0 = 1'b0; cw_static1 = 1'b1;
    next_free = cyc + 2;
    pl[0] = 8'hFF; pl[1] = 8'h00;
    plan(2, 1'b0, 0);
    run_until(prev_gend + 3);
    cw_static = 1'b0;

    next_free = cyc + 2;
    for (int i = 0; i < 12; i++) begin
      int n;
      bit tr;
      n  = int'($urandom_range(1, 4));
      tr = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 8; j++) pl[j] = 8'($urandom);
      plan(n, tr, int'($urandom_range(0, 12)));
    end
    run_until(prev_gend + 5);

    // abort a packet in the middle of its payload
    next_free = cyc + 2;
    for (int j = 0; j < 8; j++) pl[j] = 8'($urandom);
    plan(3, 1'b0, 2);
    run_until(last_s + BC * (HDR + 4) + 1);
    #2;
    mon_en = 1'b0;
    check_eq("pre-abort busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("abort rf_out", rf_out, 1'b0);
    check_eq("abort busy", busy, 1'b0);
    check_eq("abort tx_ready", tx_ready, 1'b0);
    check_eq("abort bit_strobe", bit_strobe, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = cyc - 1; c < N; c++) begin
      e_act[c] = 1'b0; e_bit[c] = 1'b0; e_busy[c] = 1'b0; e_stb[c] = 1'b0;
      e_und[c] = 1'b0; e_full[c] = 1'b0; d_val[c] = 1'b0; d_last[c] = 1'b0;
    end
    step();
    mon_en = 1'b1;
    run_until(cyc + 12);

    next_free = cyc + 2;
    prev_gend = -100;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < 8; j++) pl[j] = 8'($urandom);
      plan(n, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 6)));
    end
    run_until(prev_gend + 5);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsk_packet_mod.md
Name: fsk_packet_mod

Overview:
Downstream consumer of the PLL-derived subcarrier square waves. Packetises a byte stream into preamble, sync word, then payload. Drives the backscatter RF switch by selecting one of two subcarriers per bit: binary FSK, MSB first. Runs on the 12 MHz system clock; the subcarrier inputs are resynchronised internally.

Parameters:
BIT_CYCLES, 12000, clock cycles per transmitted bit (1 kbps at 12 MHz); legal range >= 4.
PREAMBLE_BYTES, 2, count of 8'b10101010 bytes sent before the sync word; legal range >= 1.
SYNC_WORD, 8'hD3, byte sent after the preamble.
GAP_BITS, 4, bit periods of forced-off output after each packet; legal range >= 1.

Ports:
clk_in  input  1  system clock, 12 MHz
rst_n_in  input  1  asynchronous active-low reset
cw_0_in  input  1  subcarrier for bit 0, async square wave
cw_1_in  input  1  subcarrier for bit 1, async square wave
tx_data  input  8  payload byte
tx_valid  input  1  tx_data is valid
tx_last  input  1  qualifies tx_data as the final byte of the packet
tx_ready  output  1  block can accept a byte this cycle
rf_out  output  1  RF switch drive, registered
busy  output  1  high in any state other than IDLE
bit_strobe  output  1  one-cycle pulse on the last cycle of each bit period
underrun  output  1  one-cycle pulse when a payload byte was not ready at a byte boundary

Behaviour:
- Reset (async, active-low):
  - all outputs 0.
  - FSM in IDLE; holding buffer empty; synchronisers cleared.
- Synchronisers:
  - cw_0_in and cw_1_in each pass through 2 flops.
  - rf_out = registered mux of the synced subcarriers.
  - Latency from a cw edge to rf_out is 3 clk_in cycles.
  - rf_out never glitches.
- Holding buffer:
  - One byte plus its last flag.
  - tx_ready = holding buffer empty.
  - Transfer occurs on tx_valid && tx_ready; the buffer is then full from the next cycle.
  - Bytes are accepted in any state, including GAP.
- Shift register:
  - 8-bit, plus a cur_last flag.
  - The current bit is the shift register MSB.
- Bit timer:
  - Counts 0..BIT_CYCLES-1, width $clog2(BIT_CYCLES).
  - Held at 0 in IDLE.
  - bit_strobe fires at count == BIT_CYCLES-1.
  - Bit index (0..7) advances on bit_strobe.
- FSM states: IDLE, PREAMBLE, SYNC, PAYLOAD, GAP.
  - IDLE:
    - rf_out = 0.
    - When the holding buffer is full, next cycle moves to PREAMBLE.
    - The shift register loads 8'hAA; the byte counter is 0.
  - PREAMBLE:
    - Each bit selects cw_1 if the bit is 1, cw_0 if 0.
    - After 8*PREAMBLE_BYTES bits, load SYNC_WORD and go to SYNC.
  - SYNC:
    - 8 bits.
    - At the final bit_strobe, load the holding byte into the shift register (buffer frees that cycle), then go to PAYLOAD.
  - PAYLOAD, at the final bit_strobe of a byte:
    - cur_last = 1: go to GAP.
    - Else, holding buffer full: load it and continue.
    - Else: pulse underrun and go to GAP (packet truncated).
  - GAP:
    - rf_out = 0 for GAP_BITS bit periods, then IDLE.
    - From IDLE, a full holding buffer starts the next packet, so the minimum inter-packet spacing is GAP_BITS bit periods.
- Output mapping:
  - During PREAMBLE, SYNC and PAYLOAD, rf_out follows the synced subcarrier selected by the current bit.
  - In IDLE and GAP, rf_out = 0 (registered, 1-cycle delay like the mux path).
- Simultaneous events:
  - A load from the holding buffer and a new tx handshake in the same cycle: the load empties the buffer first, then the handshake refills it.
  - tx_ready therefore stays low during that cycle, since it reflects the pre-load state; the handshake takes effect next cycle.
- busy = (state != IDLE).
- Reset mid-packet: immediate abort, all state cleared, rf_out 0 with no further pulses.

Test Plan:
1. BIT_CYCLES=4, PREAMBLE_BYTES=1, GAP_BITS=2; send one byte 8'h5A with tx_last=1 ->
   - preamble AA, sync D3, payload 5A shifted MSB first: 24 bit periods, 96 cycles.
   - bit_strobe pulses every 4th cycle; busy high for 104 cycles.
   - rf_out tracks cw_1 on 1-bits and cw_0 on 0-bits, offset 3 cycles.
2. Three-byte packet 11,22,33 (last on 33), tx_valid held high ->
   - tx_ready returns high at each byte boundary.
   - No underrun; payload bits contiguous for 24 bit periods.
3. Two bytes with no tx_last and the second byte withheld ->
   - underrun pulses exactly once at the end of byte 1.
   - GAP entered; rf_out 0 for 8 cycles; then IDLE.
4. Drive cw_0_in=0 and cw_1_in=1 static; send FF then 00 ->
   - rf_out 1 for 8 bit periods, then 0 for 8 bit periods (after preamble and sync).
5. Assert rst_n_in low mid-PAYLOAD for 1 cycle ->
   - rf_out, busy and tx_ready all 0 asynchronously.
   - After release: tx_ready=1, state IDLE, no bit_strobe.
6. Queue a new byte during GAP ->
   - Accepted (tx_ready=1 in GAP).
   - Next PREAMBLE starts exactly GAP_BITS*BIT_CYCLES+1 cycles after GAP entry.
